// File: rtl/cpu_controller.sv
// Fetch/execute sequencer for the 8-state accumulator CPU; optional CTRL_RESUME_EN adds a resume input to leave HALTED.
// Zero-latency control outputs decoded from the state register; no backpressure, one state per clock.
module cpu_controller (
    input  logic       clk,
    input  logic       rst,
`ifdef CTRL_RESUME_EN
    input  logic       resume,
`endif
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [3:0] state,
    output logic [7:0] instr_cnt
);

    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       resume_w;

`ifdef CTRL_RESUME_EN
    assign resume_w = resume;
`else
    assign resume_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INST_ADDR:  state_d = INST_FETCH;
            INST_FETCH: state_d = INST_LOAD;
            INST_LOAD:  state_d = IDLE;
            IDLE:       state_d = OP_ADDR;
            OP_ADDR:    state_d = (opcode == OP_HLT) ? HALTED : OP_FETCH;
            OP_FETCH:   state_d = ALU_OP;
            ALU_OP:     state_d = STORE;
            STORE: begin
                state_d = INST_ADDR;
                cnt_d   = cnt_q + 8'd1;
            end
            HALTED:     state_d = resume_w ? INST_ADDR : HALTED;
            default:    state_d = INST_ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INST_ADDR;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic aluop;
    assign aluop = (opcode == 3'b010) || (opcode == 3'b011) ||
                   (opcode == 3'b100) || (opcode == 3'b101);

    // zero is deliberately consulted only in ALU_OP (SKZ skip).
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        case (state_q)
            INST_ADDR:  sel = 1'b1;
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR:    inc_pc = 1'b1;
            OP_FETCH:   rd = aluop;
            ALU_OP: begin
                rd     = aluop;
                inc_pc = (opcode == OP_SKZ) && zero;
                ld_pc  = (opcode == OP_JMP);
                data_e = (opcode == OP_STO);
            end
            STORE: begin
                ld_ac  = aluop;
                ld_pc  = (opcode == OP_JMP);
                wr     = (opcode == OP_STO);
                data_e = (opcode == OP_STO);
            end
            HALTED:     halt = 1'b1;
            default:    ;
        endcase
    end

    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed instruction scenarios plus random opcode/zero/rst/resume traffic.
// Reference model tracks instruction phase, halted flag and retired count as plain integers.
module tb_cpu_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       resume;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [3:0] state;
    logic [7:0] instr_cnt;

`ifdef CTRL_RESUME_EN
    localparam bit RESUME_EN = 1'b1;
`else
    localparam bit RESUME_EN = 1'b0;
`endif

    cpu_controller dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CTRL_RESUME_EN
        .resume    (resume),
`endif
        .opcode    (opcode),
        .zero      (zero),
        .sel       (sel),
        .rd        (rd),
        .ld_ir     (ld_ir),
        .inc_pc    (inc_pc),
        .ld_pc     (ld_pc),
        .ld_ac     (ld_ac),
        .wr        (wr),
        .data_e    (data_e),
        .halt      (halt),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: cycle position within the current instruction, halted flag, retired count.
    int m_phase  = 0;
    bit m_halted = 1'b0;
    int m_cnt    = 0;
    bit m_valid  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] exp_outs(input logic [2:0] op, input logic z);
        bit a_op;
        bit s, r, li, ip, lp, la, w, de, h;
        a_op = (op >= 3'd2) && (op <= 3'd5);
        {s, r, li, ip, lp, la, w, de, h} = '0;
        if (m_halted) h = 1;
        else begin
            s  = (m_phase <= 3);
            r  = (m_phase >= 1 && m_phase <= 3) || ((m_phase == 5 || m_phase == 6) && a_op);
            li = (m_phase == 2 || m_phase == 3);
            ip = (m_phase == 4) || (m_phase == 6 && op == 3'd1 && z);
            lp = (m_phase >= 6) && (op == 3'd7);
            la = (m_phase == 7) && a_op;
            w  = (m_phase == 7) && (op == 3'd6);
            de = (m_phase >= 6) && (op == 3'd6);
        end
        return {s, r, li, ip, lp, la, w, de, h};
    endfunction

    function automatic logic [8:0] got_outs();
        return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
    endfunction

    task automatic step(input logic r, input logic [2:0] op, input logic z, input logic res);
        @(negedge clk);
        rst = r; opcode = op; zero = z; resume = res;
        #1;
        if (m_valid) begin
            check("outs",  32'(got_outs()), 32'(exp_outs(op, z)));
            check("state", 32'(state), m_halted ? 32'd8 : 32'(m_phase));
            check("cnt",   32'(instr_cnt), 32'(m_cnt));
        end
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_halted = 0; m_cnt = 0; m_valid = 1;
        end else if (m_halted) begin
            if (RESUME_EN && res) begin m_halted = 0; m_phase = 0; end
        end else if (m_phase == 4 && op == 3'd0) begin
            m_halted = 1;
        end else if (m_phase == 7) begin
            m_phase = 0; m_cnt = (m_cnt + 1) % 256;
        end else begin
            m_phase++;
        end
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z);
        for (int i = 0; i < 8; i++) step(1'b0, op, z, 1'b0);
    endtask

    initial begin
        rst = 1'b1; opcode = 3'd0; zero = 1'b0; resume = 1'b0;

        // Reset and reset-state outputs.
        step(1'b1, 3'd7, 1'b1, 1'b1);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_cnt", 32'(instr_cnt), 32'd0);
        check("rst_outs", 32'(got_outs()), 32'h100);

        // ADD: one full instruction, retires once.
        run_instr(3'd2, 1'b0);
        #1;
        check("add_state", 32'(state), 32'd0);
        check("add_cnt", 32'(instr_cnt), 32'd1);

        run_instr(3'd6, 1'b0);   // STO
        run_instr(3'd1, 1'b1);   // SKZ taken
        run_instr(3'd1, 1'b0);   // SKZ not taken
        run_instr(3'd4, 1'b1);   // XOR

        // HLT: stops in HALTED and holds with count frozen.
        for (int i = 0; i < 5; i++) step(1'b0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 1'b0);
        #1;
        check("hlt_halt", 32'(halt), 32'd1);
        check("hlt_state", 32'(state), 32'd8);
        check("hlt_cnt", 32'(instr_cnt), 32'd5);
        if (RESUME_EN) begin
            step(1'b0, 3'd2, 1'b0, 1'b1);
            #1;
            check("resume_state", 32'(state), 32'd0);
        end
        run_instr(3'd3, 1'b0);

        // Reset mid-instruction in ALU_OP of JMP.
        for (int i = 0; i < 6; i++) step(1'b0, 3'd7, 1'b0, 1'b0);
        step(1'b1, 3'd7, 1'b0, 1'b0);
        #1;
        check("jmp_rst_state", 32'(state), 32'd0);
        check("jmp_rst_ldpc", 32'(ld_pc), 32'd0);
        check("jmp_rst_cnt", 32'(instr_cnt), 32'd0);

        // 256 LDA instructions wrap the counter.
        for (int n = 0; n < 256; n++) run_instr(3'd5, 1'($urandom));
        #1;
        check("wrap_cnt", 32'(instr_cnt), 32'd0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic r;
            logic [2:0] op;
            r  = m_halted ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 199) == 0);
            op = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            step(r, op, 1'($urandom), $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
